// File: rtl/alu_pkg.sv
// Shared opcode and FSM state types for the parameterised ALU.
// The divider datapath is compiled in only when ALU_DIV_EN is defined.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_MUL = 3'b010,
        OP_DIV = 3'b011,
        OP_EQ  = 3'b100,
        OP_GT  = 3'b101,
        OP_LT  = 3'b110,
        OP_EZ  = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

endpackage

// File: rtl/alu_seq_muldiv.sv
// Iterative signed multiply (shift-add) and, with ALU_DIV_EN, restoring divide.
// Both work on magnitudes and fix the sign at the end; WIDTH iterations per operation.
module alu_seq_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  alu_op_e                 op,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic                    done,
    output logic        [WIDTH-1:0] result,
    output logic                    ovf
);

    localparam int CW = $clog2(WIDTH + 1);

    logic                 busy;
    logic [CW-1:0]        cnt;
    logic                 neg_res;
    logic [2*WIDTH-1:0]   acc, acc_nxt;
    logic [2*WIDTH-1:0]   mcand, mcand_nxt;
    logic [WIDTH-1:0]     mplier, mplier_nxt;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [2*WIDTH-1:0]   prod;
    logic                 go;

    assign a_mag = a[WIDTH-1] ? WIDTH'(-a) : a;
    assign b_mag = b[WIDTH-1] ? WIDTH'(-b) : b;

`ifdef ALU_DIV_EN
    logic             is_div;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH-1:0] quo;
    assign go = start && (op == OP_MUL || op == OP_DIV);
`else
    assign go = start && (op == OP_MUL);
`endif

    // The last iteration is taken straight from the step logic so the
    // owner can register the answer on the same edge it is produced.
    assign done = busy && (cnt == CW'(WIDTH - 1));

    always_comb begin
        acc_nxt    = acc;
        mcand_nxt  = mcand;
        mplier_nxt = mplier;
`ifdef ALU_DIV_EN
        rem_shift  = '0;
        if (is_div) begin
            // mplier holds the dividend shifting out and the quotient shifting in
            rem_shift = {acc[WIDTH-1:0], mplier[WIDTH-1]};
            if (rem_shift >= {1'b0, mcand[WIDTH-1:0]}) begin
                acc_nxt    = {{(WIDTH-1){1'b0}}, rem_shift - {1'b0, mcand[WIDTH-1:0]}};
                mplier_nxt = {mplier[WIDTH-2:0], 1'b1};
            end else begin
                acc_nxt    = {{(WIDTH-1){1'b0}}, rem_shift};
                mplier_nxt = {mplier[WIDTH-2:0], 1'b0};
            end
        end else
`endif
        begin
            if (mplier[0]) begin
                acc_nxt = acc + mcand;
            end
            mcand_nxt  = mcand << 1;
            mplier_nxt = mplier >> 1;
        end
    end

    assign prod = neg_res ? -acc_nxt : acc_nxt;

`ifdef ALU_DIV_EN
    assign quo    = neg_res ? -mplier_nxt : mplier_nxt;
    assign result = is_div ? quo : prod[WIDTH-1:0];
    // Only MIN / -1 yields a positive magnitude of 2^(WIDTH-1)
    assign ovf    = is_div ? (!neg_res && mplier_nxt[WIDTH-1])
                           : !((&prod[2*WIDTH-1:WIDTH-1]) || !(|prod[2*WIDTH-1:WIDTH-1]));
`else
    assign result = prod[WIDTH-1:0];
    assign ovf    = !((&prod[2*WIDTH-1:WIDTH-1]) || !(|prod[2*WIDTH-1:WIDTH-1]));
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy    <= 1'b0;
            cnt     <= '0;
            neg_res <= 1'b0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
`ifdef ALU_DIV_EN
            is_div  <= 1'b0;
`endif
        end else if (go) begin
            busy    <= 1'b1;
            cnt     <= '0;
            neg_res <= a[WIDTH-1] ^ b[WIDTH-1];
            acc     <= '0;
            mcand   <= {{WIDTH{1'b0}}, b_mag};
            mplier  <= a_mag;
`ifdef ALU_DIV_EN
            is_div  <= (op == OP_DIV);
`endif
        end else if (busy) begin
            acc    <= acc_nxt;
            mcand  <= mcand_nxt;
            mplier <= mplier_nxt;
            cnt    <= cnt + CW'(1);
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/param_alu.sv
// Handshaked signed ALU: single-cycle add/sub/compare, iterative mul/div.
// Divide is available only when ALU_DIV_EN is defined; otherwise opcode DIV is illegal.
module param_alu
    import alu_pkg::*;
#(
    parameter int WIDTH  = 6,
    parameter bit MUL_EN = 1'b1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    input  logic        [2:0]       op,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic        [WIDTH-1:0] result,
    output logic                    ovf,
    output logic                    neg,
    output logic                    zero,
    output alu_state_e              dbg_state
);

    // Handshake: a request is taken on a rising edge with in_valid && in_ready
    // (IDLE only); a response leaves on a rising edge with out_valid && out_ready
    // (DONE only). One request is in flight at a time; result and flags hold in DONE.

    alu_state_e       state;
    alu_op_e          op_e;
    logic             accept;
    logic             is_seq;
    logic             load;
    logic [WIDTH-1:0] sum, diff;
    logic [WIDTH-1:0] sc_res, fin_res;
    logic             sc_ovf, fin_ovf;
    logic             seq_done, seq_ovf;
    logic [WIDTH-1:0] seq_res;

    assign op_e      = alu_op_e'(op);
    assign accept    = in_valid && in_ready;
    assign dbg_state = state;
    assign sum       = a + b;
    assign diff      = a - b;

    always_comb begin
        is_seq = 1'b0;
        if (op_e == OP_MUL && MUL_EN) begin
            is_seq = 1'b1;
        end
`ifdef ALU_DIV_EN
        if (op_e == OP_DIV && b != '0) begin
            is_seq = 1'b1;
        end
`endif
    end

    // Anything not decoded here (illegal MUL/DIV, divide by zero) reports 0 with ovf
    always_comb begin
        sc_res = '0;
        sc_ovf = 1'b1;
        case (op_e)
            OP_ADD: begin
                sc_res = sum;
                sc_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res = diff;
                sc_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_EQ: begin
                sc_res = {{(WIDTH-1){1'b0}}, a == b};
                sc_ovf = 1'b0;
            end
            OP_GT: begin
                sc_res = {{(WIDTH-1){1'b0}}, a > b};
                sc_ovf = 1'b0;
            end
            OP_LT: begin
                sc_res = {{(WIDTH-1){1'b0}}, a < b};
                sc_ovf = 1'b0;
            end
            OP_EZ: begin
                sc_res = {{(WIDTH-1){1'b0}}, a == '0};
                sc_ovf = 1'b0;
            end
            default: begin
                sc_res = '0;
                sc_ovf = 1'b1;
            end
        endcase
    end

    assign load    = (state == ST_IDLE && accept && !is_seq) || (state == ST_BUSY && seq_done);
    assign fin_res = (state == ST_BUSY) ? seq_res : sc_res;
    assign fin_ovf = (state == ST_BUSY) ? seq_ovf : sc_ovf;

    alu_seq_muldiv #(.WIDTH(WIDTH)) u_seq (
        .clock  (clock),
        .reset  (reset),
        .start  (state == ST_IDLE && accept && is_seq),
        .op     (op_e),
        .a      (a),
        .b      (b),
        .done   (seq_done),
        .result (seq_res),
        .ovf    (seq_ovf)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            ovf       <= 1'b0;
            neg       <= 1'b0;
            zero      <= 1'b0;
        end else begin
            if (load) begin
                result <= fin_res;
                ovf    <= fin_ovf;
                neg    <= fin_res[WIDTH-1];
                zero   <= (fin_res == '0);
            end
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        in_ready <= 1'b0;
                        if (is_seq) begin
                            state <= ST_BUSY;
                        end else begin
                            state     <= ST_DONE;
                            out_valid <= 1'b1;
                        end
                    end
                end
                ST_BUSY: begin
                    if (seq_done) begin
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_param_alu.sv
// Directed vector bench for param_alu at WIDTH=6; expectations follow ALU_DIV_EN.
// Table of hand-computed vectors plus backpressure and reset-abort sequences.
module tb_param_alu;
    import alu_pkg::*;

    localparam int W = 6;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         ovf;
        int           lat;
    } vec_t;

    logic                clock;
    logic                reset;
    logic signed [W-1:0] a, b;
    logic [2:0]          op;
    logic                in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0]        result;
    logic                ovf, neg, zero;
    alu_state_e          dbg_state;

    logic [W:0] exp_q[$];
    vec_t       vecs[$];
    int         n_tests = 0;
    int         n_fail  = 0;

    param_alu #(.WIDTH(W), .MUL_EN(1'b1)) dut (
        .clock     (clock),
        .reset     (reset),
        .a         (a),
        .b         (b),
        .op        (op),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .ovf       (ovf),
        .neg       (neg),
        .zero      (zero),
        .dbg_state (dbg_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic add_vec(input logic [2:0] o, input int x, input int y,
                           input int r, input logic f, input int l);
        vec_t v;
        v.op  = o;
        v.a   = W'(x);
        v.b   = W'(y);
        v.res = W'(r);
        v.ovf = f;
        v.lat = l;
        vecs.push_back(v);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int         lat;
        logic [W:0] e;
        exp_q.push_back({v.res, v.ovf});
        @(negedge clock);
        op        = v.op;
        a         = v.a;
        b         = v.b;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        check($sformatf("v%0d_in_ready", idx), 32'(in_ready), 32'd1);
        @(posedge clock);
        #1;
        // scramble inputs while the operation is in flight
        in_valid = 1'b0;
        op       = 3'($urandom_range(0, 7));
        a        = W'($urandom);
        b        = W'($urandom);
        lat      = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clock);
            #1;
            lat++;
        end
        check($sformatf("v%0d_out_valid", idx), 32'(out_valid), 32'd1);
        check($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.lat));
        e = exp_q.pop_front();
        check($sformatf("v%0d_result", idx), 32'(result), 32'(e[W:1]));
        check($sformatf("v%0d_ovf", idx), 32'(ovf), 32'(e[0]));
        check($sformatf("v%0d_neg", idx), 32'(neg), 32'(e[W]));
        check($sformatf("v%0d_zero", idx), 32'(zero), 32'(e[W:1] == '0));
        @(negedge clock);
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        check($sformatf("v%0d_released", idx), 32'(out_valid), 32'd0);
    endtask

    initial begin
        int seen;
        reset     = 1'b0;
        a         = '0;
        b         = '0;
        op        = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_result", 32'(result), 32'd0);
        check("rst_flags", 32'({ovf, neg, zero}), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        reset = 1'b1;
        @(negedge clock);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));

        add_vec(OP_ADD,  31,   1, -32, 1'b1, 1);
        add_vec(OP_ADD,   2,   3,   5, 1'b0, 1);
        add_vec(OP_ADD, -32,  -1,  31, 1'b1, 1);
        add_vec(OP_SUB,   5,   7,  -2, 1'b0, 1);
        add_vec(OP_SUB, -32,   1,  31, 1'b1, 1);
        add_vec(OP_SUB,  10,  10,   0, 1'b0, 1);
        add_vec(OP_MUL,  -5,   6, -30, 1'b0, W + 1);
        add_vec(OP_MUL,   8,   8,   0, 1'b1, W + 1);
        add_vec(OP_MUL,  -4,  -8, -32, 1'b1, W + 1);
        add_vec(OP_MUL,   7,  -3, -21, 1'b0, W + 1);
        add_vec(OP_EQ,    9,   9,   1, 1'b0, 1);
        add_vec(OP_EQ,    9,  -9,   0, 1'b0, 1);
        add_vec(OP_GT,   -1,  -2,   1, 1'b0, 1);
        add_vec(OP_GT,   -3,   2,   0, 1'b0, 1);
        add_vec(OP_LT,  -32,  31,   1, 1'b0, 1);
        add_vec(OP_EZ,    0,   5,   1, 1'b0, 1);
        add_vec(OP_EZ,    1,   0,   0, 1'b0, 1);
`ifdef ALU_DIV_EN
        add_vec(OP_DIV, -17,   4,  -4, 1'b0, W + 1);
        add_vec(OP_DIV, -32,  -1, -32, 1'b1, W + 1);
        add_vec(OP_DIV,   7,   0,   0, 1'b1, 1);
        add_vec(OP_DIV,  20,  -3,  -6, 1'b0, W + 1);
        add_vec(OP_DIV,  31,  31,   1, 1'b0, W + 1);
`else
        add_vec(OP_DIV, -17,   4,   0, 1'b1, 1);
        add_vec(OP_DIV,   7,   0,   0, 1'b1, 1);
`endif

        foreach (vecs[i]) begin
            run_vec(vecs[i], i);
        end

        // Backpressure: LT held in DONE while a second request waits on in_valid
        @(negedge clock);
        op        = OP_LT;
        a         = -6'sd3;
        b         = 6'sd2;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clock);
        #1;
        op = OP_ADD;
        a  = 6'sd2;
        b  = 6'sd3;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check($sformatf("bp%0d_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("bp%0d_result", i), 32'(result), 32'd1);
            check($sformatf("bp%0d_in_ready", i), 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        check("bp_transfer_valid", 32'(out_valid), 32'd0);
        check("bp_transfer_in_ready", 32'(in_ready), 32'd1);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        check("bp_next_valid", 32'(out_valid), 32'd1);
        check("bp_next_result", 32'(result), 32'd5);
        @(negedge clock);
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;

        // Reset three cycles into a MUL aborts it without a response
        @(negedge clock);
        op       = OP_MUL;
        a        = -6'sd5;
        b        = 6'sd6;
        in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("abort_result", 32'(result), 32'd0);
        check("abort_flags", 32'({ovf, neg, zero}), 32'd0);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        seen  = 0;
        repeat (2 * W + 4) begin
            @(posedge clock);
            #1;
            if (out_valid) seen++;
        end
        check("abort_no_response", 32'(seen), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        vecs.delete();
        add_vec(OP_ADD, 2, 3, 5, 1'b0, 1);
        run_vec(vecs[0], 99);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
